// File: rtl/axi_cfg_sequencer.sv
// Config-space command sequencer: queues tagged reads/writes, issues them one at a time to the
// AXI-lite adapter and returns one response per command. Optional reissue on error: AXI_CFG_RETRY_EN.
module axi_cfg_sequencer #(
  parameter int DEPTH     = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic        axi_clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic [3:0]  cmd_tag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_wr,
  output logic [3:0]  rsp_tag,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  output logic [31:0] axi_rdwr_addr,
  output logic [31:0] axi_wr_data,
  output logic        axi_rd_go,
  output logic        axi_wr_go,
  input  logic [31:0] axi_rd_data,
  input  logic        axi_rd_done,
  input  logic        axi_wr_done,
  input  logic        axi_error,
  output logic        busy,
  output logic [15:0] err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [RW-1:0] RETRY_ONE = RW'(1);
`ifdef AXI_CFG_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Command queue storage; data-path only, so no reset needed.
  logic        q_wr   [DEPTH];
  logic [31:0] q_addr [DEPTH];
  logic [31:0] q_data [DEPTH];
  logic [3:0]  q_tag  [DEPTH];

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          cmd_ready_q;

  logic          if_wr_q;
  logic [31:0]   if_addr_q, if_data_q;
  logic [3:0]    if_tag_q;
  logic [31:0]   rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;
  logic [15:0]   err_cnt_q;
  logic [RW-1:0] retry_cnt_q, retry_cnt_d;

  logic push, pop, load_if, set_rsp, retry_ok;

  assign push     = cmd_valid && cmd_ready_q;
  assign pop      = (state_q == S_IDLE) && (count_q != '0);
  assign retry_ok = RETRY_EN && (retry_cnt_q < RETRY_MAX);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!push && pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (push) begin
      q_wr[wr_ptr_q]   <= cmd_wr;
      q_addr[wr_ptr_q] <= cmd_addr;
      q_data[wr_ptr_q] <= cmd_data;
      q_tag[wr_ptr_q]  <= cmd_tag;
    end
  end

  always_comb begin
    state_d     = state_q;
    load_if     = 1'b0;
    set_rsp     = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = 32'h0;
    retry_cnt_d = retry_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d     = S_ISSUE;
          load_if     = 1'b1;
          retry_cnt_d = '0;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // Error outranks any done seen in the same cycle.
        if (axi_error) begin
          if (retry_ok) begin
            state_d     = S_ISSUE;
            retry_cnt_d = retry_cnt_q + RETRY_ONE;
          end else begin
            state_d   = S_RESP;
            set_rsp   = 1'b1;
            rsp_err_d = 1'b1;
          end
        end else if (if_wr_q ? axi_wr_done : axi_rd_done) begin
          state_d    = S_RESP;
          set_rsp    = 1'b1;
          rsp_data_d = if_wr_q ? 32'h0 : axi_rd_data;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b0;
      if_wr_q     <= 1'b0;
      if_addr_q   <= 32'h0;
      if_data_q   <= 32'h0;
      if_tag_q    <= 4'h0;
      rsp_data_q  <= 32'h0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= 16'h0;
      retry_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      cmd_ready_q <= (count_d != CNT_FULL);
      retry_cnt_q <= retry_cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (load_if) begin
        if_wr_q   <= q_wr[rd_ptr_q];
        if_addr_q <= q_addr[rd_ptr_q];
        if_data_q <= q_data[rd_ptr_q];
        if_tag_q  <= q_tag[rd_ptr_q];
      end
      if (set_rsp) begin
        rsp_data_q <= rsp_data_d;
        rsp_err_q  <= rsp_err_d;
        if (rsp_err_d && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'h1;
      end
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign axi_rd_go     = (state_q == S_ISSUE) && !if_wr_q;
  assign axi_wr_go     = (state_q == S_ISSUE) && if_wr_q;
  assign axi_rdwr_addr = if_addr_q;
  assign axi_wr_data   = if_data_q;
  assign rsp_valid     = (state_q == S_RESP);
  assign rsp_wr        = if_wr_q;
  assign rsp_tag       = if_tag_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_error     = rsp_err_q;
  assign busy          = (count_q != '0) || (state_q != S_IDLE);
  assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_axi_cfg_sequencer.sv
// Bench for axi_cfg_sequencer: behavioural adapter + command/response scoreboard, directed cases
// followed by a randomized phase. Honours AXI_CFG_RETRY_EN when defined.
module tb_axi_cfg_sequencer;

  localparam int DEPTH     = 4;
  localparam int MAX_RETRY = 2;
`ifdef AXI_CFG_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic        axi_clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [31:0] cmd_addr, cmd_data;
  logic [3:0]  cmd_tag;
  logic        rsp_valid, rsp_ready, rsp_wr, rsp_error;
  logic [3:0]  rsp_tag;
  logic [31:0] rsp_data;
  logic [31:0] axi_rdwr_addr, axi_wr_data, axi_rd_data;
  logic        axi_rd_go, axi_wr_go, axi_rd_done, axi_wr_done, axi_error;
  logic        busy;
  logic [15:0] err_count;

  axi_cfg_sequencer #(.DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY)) dut (
    .axi_clk(axi_clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_tag(cmd_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
    .rsp_tag(rsp_tag), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .axi_rdwr_addr(axi_rdwr_addr), .axi_wr_data(axi_wr_data),
    .axi_rd_go(axi_rd_go), .axi_wr_go(axi_wr_go), .axi_rd_data(axi_rd_data),
    .axi_rd_done(axi_rd_done), .axi_wr_done(axi_wr_done), .axi_error(axi_error),
    .busy(busy), .err_count(err_count)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {logic wr; logic [31:0] addr; logic [31:0] data; logic [3:0] tag;} cmd_t;
  typedef struct {logic wr; logic [3:0] tag; logic [31:0] data; logic err;} rsp_t;

  cmd_t        exp_cmd[$];
  rsp_t        exp_rsp[$];
  int          attempts = 0;
  int          model_err = 0;
  int          go_cnt = 0;
  int          vld_cnt = 0;
  int          rst_epoch = 0;
  int          force_mode = 1;   // 0 random outcome, 1 always done, 2 error together with done
  int          lat_force = 0;
  int          rdy_mode = 2;     // 0 random, 1 held low, 2 always high
  bit          stall = 1'b0;
  bit          rd_force_en = 1'b0;
  logic [31:0] rd_force = 32'h0;

  always @(negedge axi_clk) begin
    if (rst_n && (axi_rd_go || axi_wr_go)) go_cnt++;
    if (rst_n && rsp_valid) vld_cnt++;
  end

  always @(posedge axi_clk) begin
    #1;
    case (rdy_mode)
      0:       rsp_ready = ($urandom_range(0, 2) != 0);
      1:       rsp_ready = 1'b0;
      default: rsp_ready = 1'b1;
    endcase
  end

  // Adapter model: answers each go pulse and predicts the resulting response.
  task automatic serve_go();
    cmd_t        c;
    rsp_t        r;
    bit          err, fin, is_wr;
    logic [31:0] rv;
    int          lat, guard, ep;
    ep    = rst_epoch;
    is_wr = axi_wr_go;
    chk("go_both", 64'(axi_rd_go && axi_wr_go), 64'(0));
    chk("go_expected", 64'(exp_cmd.size() != 0), 64'(1));
    if (exp_cmd.size() == 0) begin
      @(negedge axi_clk);
      return;
    end
    c = exp_cmd[0];
    chk("go_kind", 64'(is_wr), 64'(c.wr));
    chk("go_addr", 64'(axi_rdwr_addr), 64'(c.addr));
    if (c.wr) chk("go_wdata", 64'(axi_wr_data), 64'(c.data));
    attempts++;
    err = (force_mode == 2) ? 1'b1 : (force_mode == 1) ? 1'b0 : ($urandom_range(0, 7) == 0);
    fin = !err || !RETRY || (attempts > MAX_RETRY);
    lat = (lat_force > 0) ? lat_force : $urandom_range(1, 5);
    rv  = rd_force_en ? rd_force : $urandom;
    @(negedge axi_clk);
    chk("go_pulse", 64'(axi_rd_go || axi_wr_go), 64'(0));
    guard = 0;
    while (stall && rst_n && guard < 1000) begin
      @(negedge axi_clk);
      guard++;
    end
    chk("stall_bound", 64'(guard < 1000), 64'(1));
    if (ep != rst_epoch) return;
    repeat (lat - 1) @(negedge axi_clk);
    if (ep != rst_epoch) return;
    if (!is_wr && !err) begin
      @(posedge axi_clk); #1;
      axi_wr_done = 1'b1;
      @(negedge axi_clk);
      chk("rd_ignores_wr_done", 64'(rsp_valid), 64'(0));
    end
    @(posedge axi_clk); #1;
    axi_error = err;
    if (!err || force_mode == 2) begin
      if (is_wr) begin
        axi_wr_done = 1'b1;
      end else begin
        axi_rd_done = 1'b1;
        axi_wr_done = 1'b1;
        axi_rd_data = rv;
      end
    end
    if (fin) begin
      r.wr   = c.wr;
      r.tag  = c.tag;
      r.err  = err;
      r.data = (!c.wr && !err) ? rv : 32'h0;
      exp_rsp.push_back(r);
      void'(exp_cmd.pop_front());
      if (err) begin
        model_err++;
        chk("err_attempts", 64'(attempts), RETRY ? 64'(MAX_RETRY + 1) : 64'(1));
      end
      attempts = 0;
    end
    @(negedge axi_clk);
    chk("rsp_not_early", 64'(rsp_valid), 64'(0));
    @(posedge axi_clk); #1;
    axi_error   = 1'b0;
    axi_rd_done = 1'b0;
    axi_wr_done = 1'b0;
    axi_rd_data = 32'h0;
    @(negedge axi_clk);
    chk("rsp_at_done_plus1", 64'(rsp_valid), 64'(fin));
    if (!fin) chk("retry_reissue", 64'(axi_rd_go || axi_wr_go), 64'(1));
  endtask

  always begin
    @(negedge axi_clk);
    while (rst_n && (axi_rd_go || axi_wr_go)) serve_go();
  end

  // Response consumer: ordering, contents, stability under back-pressure.
  bit          hold = 1'b0;
  logic [37:0] held;
  always @(negedge axi_clk) begin
    rsp_t r;
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (rsp_valid) chk("no_go_in_resp", 64'({axi_rd_go, axi_wr_go}), 64'(0));
      if (hold) chk("rsp_stable", 64'({rsp_valid, rsp_tag, rsp_wr, rsp_error, rsp_data}), 64'({1'b1, held}));
      if (rsp_valid && rsp_ready) begin
        chk("rsp_expected", 64'(exp_rsp.size() != 0), 64'(1));
        if (exp_rsp.size() != 0) begin
          r = exp_rsp.pop_front();
          chk("rsp_fields", 64'({rsp_tag, rsp_wr, rsp_error, rsp_data}), 64'({r.tag, r.wr, r.err, r.data}));
        end
      end
      hold = rsp_valid && !rsp_ready;
      held = {rsp_tag, rsp_wr, rsp_error, rsp_data};
    end
  end

  // Called and returns at posedge+1; leaves cmd_valid high.
  task automatic push_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] t);
    cmd_t c;
    int   g;
    bit   ok;
    g  = 0;
    ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_tag   = t;
    while (!ok && g < 2000) begin
      @(negedge axi_clk);
      if (cmd_ready) begin
        c.wr = wr; c.addr = a; c.data = d; c.tag = t;
        exp_cmd.push_back(c);
        ok = 1'b1;
      end
      @(posedge axi_clk); #1;
      g++;
    end
    chk("push_accept", 64'(ok), 64'(1));
  endtask

  task automatic wait_idle(input string tag);
    int g;
    g = 0;
    while (!(exp_cmd.size() == 0 && exp_rsp.size() == 0 && !busy && !rsp_valid) && g < 3000) begin
      @(negedge axi_clk);
      g++;
    end
    chk(tag, 64'(g < 3000), 64'(1));
    @(posedge axi_clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int g0, k, g;
    cmd_t c;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 32'h0; cmd_data = 32'h0; cmd_tag = 4'h0;
    rsp_ready = 1'b0;
    axi_rd_data = 32'h0; axi_rd_done = 1'b0; axi_wr_done = 1'b0; axi_error = 1'b0;

    #2;
    chk("reset_outputs", 64'({cmd_ready, rsp_valid, busy, axi_rd_go, axi_wr_go, rsp_error, rsp_tag, err_count}), 64'(0));
    chk("reset_data", 64'({rsp_data, axi_rdwr_addr}), 64'(0));
    repeat (3) @(negedge axi_clk);
    rst_n = 1'b1;
    @(negedge axi_clk);
    chk("ready_after_reset", 64'(cmd_ready), 64'(1));
    @(posedge axi_clk); #1;

    // Single write, done five cycles after go.
    force_mode = 1; lat_force = 5; g0 = go_cnt;
    push_cmd(1'b1, 32'h4, 32'hDEADBEEF, 4'd3);
    cmd_valid = 1'b0;
    wait_idle("drain_write");
    chk("write_go_count", 64'(go_cnt - g0), 64'(1));

    // Single read with known data.
    rd_force_en = 1'b1; rd_force = 32'h12345678; lat_force = 2;
    push_cmd(1'b0, 32'h8, 32'h0, 4'd5);
    cmd_valid = 1'b0;
    wait_idle("drain_read");
    rd_force_en = 1'b0; lat_force = 0;

    // Fill while the bus is stalled: one in flight plus DEPTH queued.
    stall = 1'b1; k = 0; cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      cmd_wr = 1'b1; cmd_addr = 32'(k * 4); cmd_data = $urandom; cmd_tag = 4'(k);
      @(negedge axi_clk);
      if (cmd_ready) begin
        c.wr = cmd_wr; c.addr = cmd_addr; c.data = cmd_data; c.tag = cmd_tag;
        exp_cmd.push_back(c);
        k++;
      end
      @(posedge axi_clk); #1;
    end
    cmd_valid = 1'b0;
    chk("fill_accepted", 64'(k), 64'(DEPTH + 1));
    @(negedge axi_clk);
    chk("full_not_ready", 64'(cmd_ready), 64'(0));
    @(posedge axi_clk); #1;
    stall = 1'b0;
    wait_idle("drain_fill");

    // Error coincident with rd_done.
    force_mode = 2; g0 = go_cnt;
    push_cmd(1'b0, 32'h10, 32'h0, 4'd7);
    cmd_valid = 1'b0;
    wait_idle("drain_error");
    chk("err_count_one", 64'(err_count), 64'(1));
    chk("error_go_count", 64'(go_cnt - g0), RETRY ? 64'(MAX_RETRY + 1) : 64'(1));
    force_mode = 1;

    // Back-pressure: response held, next command must wait.
    rdy_mode = 1;
    push_cmd(1'b1, 32'h20, 32'hA5A5A5A5, 4'd8);
    push_cmd(1'b1, 32'h24, 32'h5A5A5A5A, 4'd9);
    cmd_valid = 1'b0;
    g = 0;
    while (!rsp_valid && g < 200) begin
      @(negedge axi_clk);
      g++;
    end
    chk("hold_rsp_seen", 64'(rsp_valid), 64'(1));
    g0 = go_cnt;
    repeat (10) @(negedge axi_clk);
    chk("hold_no_go", 64'(go_cnt - g0), 64'(0));
    chk("hold_valid", 64'(rsp_valid), 64'(1));
    rdy_mode = 2;
    g = 0;
    while (go_cnt == g0 && g < 200) begin
      @(negedge axi_clk);
      g++;
    end
    chk("next_issue", 64'(go_cnt - g0), 64'(1));
    wait_idle("drain_hold");

    // Reset while waiting on the bus, with another command queued.
    stall = 1'b1;
    push_cmd(1'b0, 32'h30, 32'h0, 4'd10);
    push_cmd(1'b1, 32'h34, 32'h11111111, 4'd11);
    cmd_valid = 1'b0;
    repeat (6) @(negedge axi_clk);
    chk("pre_reset_busy", 64'(busy), 64'(1));
    #2;
    rst_n = 1'b0;
    rst_epoch++;
    #1;
    chk("reset_go_low", 64'({axi_rd_go, axi_wr_go}), 64'(0));
    chk("reset_rsp_low", 64'(rsp_valid), 64'(0));
    chk("reset_busy_low", 64'(busy), 64'(0));
    exp_cmd.delete();
    exp_rsp.delete();
    attempts = 0;
    model_err = 0;
    repeat (3) @(negedge axi_clk);
    stall = 1'b0;
    rst_n = 1'b1;
    g0 = go_cnt; g = vld_cnt;
    repeat (20) @(negedge axi_clk);
    chk("post_reset_no_go", 64'(go_cnt - g0), 64'(0));
    chk("post_reset_no_rsp", 64'(vld_cnt - g), 64'(0));
    chk("post_reset_err_count", 64'(err_count), 64'(model_err));
    @(posedge axi_clk); #1;

    // Randomized traffic.
    force_mode = 0; rdy_mode = 0; lat_force = 0;
    for (int i = 0; i < 40; i++) begin
      push_cmd(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 1) begin
        cmd_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge axi_clk);
        #1;
      end
    end
    cmd_valid = 1'b0;
    wait_idle("drain_random");
    chk("random_err_count", 64'(err_count), 64'(model_err));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
